// File: rtl/ysyx_pkg.sv
// Shared bus constants: RTC word addresses and AXI response codes.
package ysyx_pkg;

  localparam int          ADDR_W = 32;
  localparam int          DATA_W = 32;
  localparam logic [31:0] RTC_LO = 32'h0200_0048;
  localparam logic [31:0] RTC_HI = RTC_LO + 32'd4;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  // One registered read beat: everything the R channel presents at once.
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    axi_resp_e   resp;
  } rd_rsp_t;

  // Select the 32-bit mtime word addressed by a read; anything else decodes to DECERR.
  function automatic rd_rsp_t rtc_decode(input logic [31:0] addr,
                                         input logic [63:0] mtime,
                                         input logic [3:0]  id);
    rd_rsp_t r;
    r.id = id;
    if (addr == RTC_LO) begin
      r.data = mtime[31:0];
      r.resp = RESP_OKAY;
    end else if (addr == RTC_HI) begin
      r.data = mtime[63:32];
      r.resp = RESP_OKAY;
    end else begin
      r.data = '0;
      r.resp = RESP_DECERR;
    end
    return r;
  endfunction

endpackage

// File: rtl/ysyx_clint_mtime.sv
// Free-running 64-bit mtime counter with synchronous clear; wraps naturally.
module ysyx_clint_mtime
  import ysyx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] mtime
);

  logic [63:0] cnt_q;

  // Count every non-reset cycle.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_q + 64'd1;
  end

  assign mtime = cnt_q;

endmodule

// File: rtl/ysyx_clint.sv
// CLINT mtime slave: 64-bit timer readable as two words, inert write responder.
module ysyx_clint
  import ysyx_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // read address
  input  logic [1:0]        arburst,
  input  logic [2:0]        arsize,
  input  logic [7:0]        arlen,
  input  logic [3:0]        arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready_o,
  // read data
  output logic [3:0]        rid,
  output logic              rlast_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        rresp_o,
  output logic              rvalid_o,
  input  logic              rready,
  // write address
  input  logic [1:0]        awburst,
  input  logic [2:0]        awsize,
  input  logic [7:0]        awlen,
  input  logic [3:0]        awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready_o,
  // write data
  input  logic              wlast,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready_o,
  // write response
  output logic [3:0]        bid,
  output logic [1:0]        bresp_o,
  output logic              bvalid_o,
  input  logic              bready
);

  logic [63:0] mtime;

  ysyx_clint_mtime u_mtime (
    .clk   (clk),
    .rst   (rst),
    .mtime (mtime)
  );

  // ---------------- read channel ----------------
  logic    rvalid_q;
  rd_rsp_t rsp_q, rsp_nxt;
  logic    ar_hs, r_hs;

  assign ar_hs   = arvalid & ~rvalid_q;
  assign r_hs    = rvalid_q & rready;
  assign rsp_nxt = rtc_decode(araddr[31:0], mtime, arid);

  // Single outstanding read: capture the addressed word at accept, hold until rready.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rsp_q    <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rsp_q    <= rsp_nxt;
    end else if (r_hs) begin
      rvalid_q <= 1'b0;
      rsp_q    <= '0;
    end
  end

  assign arready_o = ~rvalid_q;
  assign rvalid_o  = rvalid_q;
  assign rlast_o   = rvalid_q;
  assign rid       = rsp_q.id;
  assign rdata_o   = rsp_q.data;
  assign rresp_o   = rsp_q.resp;

  // ---------------- write channel ----------------
  logic       aw_taken_q, w_taken_q, bvalid_q;
  logic [3:0] bid_q;
  logic       aw_hs, w_hs, b_hs;

  assign aw_hs = awvalid & ~aw_taken_q;
  assign w_hs  = wvalid & ~w_taken_q;
  assign b_hs  = bvalid_q & bready;

  // Take AW and W in any order; respond OKAY once both are in, re-arm after B handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_taken_q <= 1'b0;
      w_taken_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
    end else if (b_hs) begin
      aw_taken_q <= 1'b0;
      w_taken_q  <= 1'b0;
      bvalid_q   <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_taken_q <= 1'b1;
        bid_q      <= awid;
      end
      if (w_hs) w_taken_q <= 1'b1;
      if ((aw_taken_q | aw_hs) & (w_taken_q | w_hs)) bvalid_q <= 1'b1;
    end
  end

  assign awready_o = ~aw_taken_q;
  assign wready_o  = ~w_taken_q;
  assign bvalid_o  = bvalid_q;
  assign bid       = bid_q;
  assign bresp_o   = RESP_OKAY;

  // Burst attributes, write address/data and the upper address bits carry no meaning here.
  logic unused;
  assign unused = ^{arburst, arsize, arlen, awburst, awsize, awlen,
                    awaddr, wlast, wdata, wstrb, araddr};

endmodule

// File: tb/tb_ysyx_clint.sv
// Directed + randomized bench for ysyx_clint against a cycle-count mtime model.
module tb_ysyx_clint;

  localparam logic [31:0] LO = 32'h0200_0048;
  localparam logic [31:0] HI = 32'h0200_004C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  arid = '0, awid = '0, rid, bid;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0, rdata_o;
  logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic        arready_o, rlast_o, rvalid_o, awready_o, wready_o, bvalid_o;
  logic [1:0]  rresp_o, bresp_o;

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_clint dut (
    .clk(clk), .rst(rst),
    .arburst(2'b01), .arsize(3'b010), .arlen(8'd0), .arid(arid), .araddr(araddr),
    .arvalid(arvalid), .arready_o(arready_o),
    .rid(rid), .rlast_o(rlast_o), .rdata_o(rdata_o), .rresp_o(rresp_o),
    .rvalid_o(rvalid_o), .rready(rready),
    .awburst(2'b01), .awsize(3'b010), .awlen(8'd0), .awid(awid), .awaddr(awaddr),
    .awvalid(awvalid), .awready_o(awready_o),
    .wlast(1'b1), .wdata(wdata), .wstrb(4'hF), .wvalid(wvalid), .wready_o(wready_o),
    .bid(bid), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready(bready)
  );

  always #5 clk = ~clk;

  // Reference time: number of non-reset edges since the last reset, or a loaded value.
  logic [63:0] m = '0;
  logic        ld = 1'b0;
  logic [63:0] ld_val = '0;
  always @(posedge clk) begin
    if (rst)     m <= '0;
    else if (ld) m <= ld_val + 64'd1;
    else         m <= m + 64'd1;
  end

  function automatic logic [63:0] cur_mtime();
    return ld ? ld_val : m;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected read word: plain address match on the two RTC words.
  function automatic logic [33:0] exp_rd(input logic [31:0] a, input logic [63:0] t);
    if (a == LO)      return {2'b00, t[31:0]};
    else if (a == HI) return {2'b00, t[63:32]};
    else              return {2'b11, 32'h0};
  endfunction

  // Called at a negedge with the read channel idle. Leaves rvalid_o high.
  task automatic rd_issue(input logic [31:0] a, input logic [3:0] id, output logic [33:0] e);
    arvalid = 1'b1; araddr = a; arid = id;
    chk("arready_idle", arready_o, 1);
    e = exp_rd(a, cur_mtime());
    @(posedge clk); @(negedge clk);
    ld = 1'b0;
    arvalid = 1'b0;
    chk("rvalid", rvalid_o, 1);
    chk("rdata", rdata_o, e[31:0]);
    chk("rresp", rresp_o, e[33:32]);
    chk("rid", rid, id);
    chk("rlast", rlast_o, 1);
  endtask

  task automatic rd_finish(input int dly, input logic [33:0] e);
    for (int i = 0; i < dly; i++) begin
      @(posedge clk); @(negedge clk);
      chk("rvalid_hold", {rvalid_o, arready_o, rdata_o}, {2'b10, e[31:0]});
    end
    rready = 1'b1;
    @(posedge clk); @(negedge clk);
    rready = 1'b0;
    chk("r_clear", {rvalid_o, arready_o, rdata_o}, {2'b01, 32'h0});
  endtask

  // mode 0: AW and W together, 1: AW first, 2: W first.
  task automatic wr(input int mode, input logic [3:0] id, input int dly);
    awid = id; wdata = $urandom; awaddr = $urandom;
    awvalid = (mode != 2); wvalid = (mode != 1);
    @(posedge clk); @(negedge clk);
    if (mode != 0) begin
      chk("b_wait_one", {bvalid_o, awready_o, wready_o}, {1'b0, mode == 2, mode == 1});
      awvalid = ~awvalid; wvalid = ~wvalid;
      @(posedge clk); @(negedge clk);
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bvalid", {bvalid_o, awready_o, wready_o}, 3'b100);
    chk("bid", bid, id);
    chk("bresp", bresp_o, 0);
    for (int i = 0; i < dly; i++) begin
      @(posedge clk); @(negedge clk);
      chk("b_hold", {bvalid_o, bid}, {1'b1, id});
    end
    bready = 1'b1;
    @(posedge clk); @(negedge clk);
    bready = 1'b0;
    chk("b_rearm", {bvalid_o, awready_o, wready_o}, 3'b011);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [33:0] e, e2;
    logic [31:0] a;
    // 1. reset, then read LO with mtime=10 at accept
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", {rvalid_o, bvalid_o, rdata_o, rresp_o, rid, bid},
        {2'b00, 32'h0, 2'b00, 4'h0, 4'h0});
    chk("rst_mtime", dut.mtime, 0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rd_issue(LO, 4'h5, e);
    chk("t1_rdata10", rdata_o, 32'd10);
    rd_finish(0, e);

    // 2. low word at all-ones: LO then HI shows the carry
    force dut.u_mtime.cnt_q = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.u_mtime.cnt_q;
    ld = 1'b1; ld_val = 64'h0000_0000_FFFF_FFFF;
    rd_issue(LO, 4'h1, e);
    chk("t2_lo", rdata_o, 32'hFFFF_FFFF);
    rd_finish(0, e);
    rd_issue(HI, 4'h2, e);
    chk("t2_hi", rdata_o, 32'h1);
    rd_finish(0, e);

    // 3. arvalid held with rready low: response frozen, no second accept
    rd_issue(LO, 4'h7, e);
    arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      chk("t3_hold", {rvalid_o, arready_o, rdata_o, rid}, {2'b10, e[31:0], 4'h7});
    end
    rready = 1'b1;
    @(posedge clk); @(negedge clk);
    rready = 1'b0;
    chk("t3_no_accept_on_clear", {rvalid_o, arready_o}, 2'b01);
    arvalid = 1'b0;

    // 4. unmapped address -> DECERR
    rd_issue(32'h0200_0000, 4'hA, e);
    chk("t4_decerr", {rresp_o, rdata_o, rid}, {2'b11, 32'h0, 4'hA});
    rd_finish(1, e);

    // 5. AW+W together, then a read still sees time moving
    rd_issue(LO, 4'h0, e);
    rd_finish(0, e);
    wr(0, 4'h3, 0);
    rd_issue(LO, 4'h0, e2);
    chk("t5_increment", e2[31:0] > e[31:0], 1);
    rd_finish(0, e2);

    // randomized mix of reads and writes, with a write overlapping a read
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 2))
        0: a = LO;
        1: a = HI;
        default: begin
          a = $urandom;
          if (a == LO || a == HI) a = 32'h1000_0000;
        end
      endcase
      if ($urandom_range(0, 1) == 1) begin
        rd_issue(a, 4'($urandom), e);
        rd_finish($urandom_range(0, 3), e);
      end else if ($urandom_range(0, 1) == 1) begin
        wr($urandom_range(0, 2), 4'($urandom), $urandom_range(0, 3));
      end else begin
        rd_issue(a, 4'($urandom), e);
        wr($urandom_range(0, 2), 4'($urandom), 0);
        chk("ovl_rdata", {rvalid_o, rdata_o}, {1'b1, e[31:0]});
        rd_finish(0, e);
      end
    end

    // 6. reset with a read response pending
    rd_issue(HI, 4'h9, e);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("t6_rvalid", {rvalid_o, rdata_o, rid}, {1'b0, 32'h0, 4'h0});
    chk("t6_mtime", dut.mtime, 0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    rd_issue(LO, 4'h4, e);
    chk("t6_restart", rdata_o, 32'd1);
    rd_finish(0, e);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
